// File: rtl/ternary_mvm_core_pkg.sv
// Shared opcodes, FSM states, ternary weight codes and the output shift/saturate helper.
// Pure definitions: no latency, no flow control.
package ternary_pkg;

  localparam logic [3:0] OP_LOAD = 4'hA;
  localparam logic [3:0] OP_RUN  = 4'h5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OUT
  } state_t;

  // 00 and 10 both decode to zero weight
  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  localparam int SAT_W = 32;

  function automatic logic [7:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                           input logic [3:0] shift);
    logic signed [SAT_W-1:0] s;
    s = acc >>> shift;
    if (s > 32'sd127) begin
      return 8'h7F;
    end else if (s < -32'sd128) begin
      return 8'h80;
    end else begin
      return s[7:0];
    end
  endfunction

endpackage

// File: rtl/ternary_mvm_core_acc_lane.sv
// One output accumulator: adds, subtracts or holds the activation per ternary weight.
// Updates on the cycle en is high; no backpressure (driven by the core FSM).
module ternary_acc_lane
  import ternary_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int ACC_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [1:0]              w,
  input  logic signed [ACT_W-1:0] x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] x_ext;
  assign x_ext = {{(ACC_W-ACT_W){x[ACT_W-1]}}, x};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      if (w == W_POS) begin
        acc <= acc + x_ext;
      end else if (w == W_NEG) begin
        acc <= acc - x_ext;
      end
    end
  end

endmodule

// File: rtl/ternary_mvm_core.sv
// Ternary matrix-vector engine: loads a run-time-sized weight matrix, accumulates activations, streams int8 results.
// First result one cycle after entering OUT, then one per cycle; input stalls via in_valid, output has no backpressure.
module ternary_mvm_core
  import ternary_pkg::*;
#(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 16,
  parameter int ACT_W   = 8,
  parameter int ACC_W   = ACT_W + $clog2(IN_LEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy
);

  localparam logic [4:0] IN_MAX  = 5'(IN_LEN);
  localparam logic [4:0] OUT_MAX = 5'(OUT_LEN);

  state_t                  state;
  logic [1:0]              w [IN_LEN][OUT_LEN];
  logic [4:0]              n_in;
  logic [4:0]              n_out;
  logic [3:0]              shift;
  logic [3:0]              i_cnt;
  logic [3:0]              j_cnt;
  logic                    c_cnt;
  logic signed [ACC_W-1:0] acc [OUT_LEN];

  logic [3:0]              opcode;
  logic [4:0]              req_in;
  logic [4:0]              req_out;
  logic [4:0]              n_chunks;
  logic                    i_last;
  logic                    c_last;
  logic                    j_last;
  logic                    run_step;
  logic                    acc_clr;
  logic signed [SAT_W-1:0] acc_sel;

  assign opcode   = in_data[15:12];
  assign req_in   = {1'b0, in_data[7:4]} + 5'd1;
  assign req_out  = {1'b0, in_data[3:0]} + 5'd1;
  assign n_chunks = (n_out + 5'd7) >> 3;

  // Wrap checks use the run-time sizes, not the parameters
  assign i_last = ({1'b0, i_cnt} == n_in - 5'd1);
  assign c_last = ({4'b0, c_cnt} == n_chunks - 5'd1);
  assign j_last = ({1'b0, j_cnt} == n_out - 5'd1);

  assign run_step = (state == RUN) && in_valid;
  assign acc_clr  = (state == IDLE) && in_valid && (opcode == OP_RUN);
  assign acc_sel  = {{(SAT_W-ACC_W){acc[j_cnt][ACC_W-1]}}, acc[j_cnt]};
  assign busy     = (state != IDLE);

  for (genvar j = 0; j < OUT_LEN; j++) begin : g_lane
    localparam logic [4:0] JV = 5'(j);
    ternary_acc_lane #(
      .ACT_W(ACT_W),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (acc_clr),
      .en   (run_step && (JV < n_out)),
      .w    (w[i_cnt][j]),
      .x    (in_data[ACT_W-1:0]),
      .acc  (acc[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_in      <= IN_MAX;
      n_out     <= OUT_MAX;
      shift     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      c_cnt     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < IN_LEN; i++) begin
        for (int j = 0; j < OUT_LEN; j++) begin
          w[i][j] <= 2'b00;
        end
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (opcode == OP_LOAD) begin
              n_in  <= (req_in > IN_MAX) ? IN_MAX : req_in;
              n_out <= (req_out > OUT_MAX) ? OUT_MAX : req_out;
              i_cnt <= '0;
              c_cnt <= 1'b0;
              state <= LOAD;
            end else if (opcode == OP_RUN) begin
              shift <= in_data[3:0];
              i_cnt <= '0;
              state <= RUN;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            // Full chunk is written even past n_out; those lanes are never enabled
            for (int k = 0; k < 8; k++) begin
              w[i_cnt][{c_cnt, 3'(k)}] <= in_data[2*k +: 2];
            end
            if (c_last) begin
              c_cnt <= 1'b0;
              if (i_last) begin
                i_cnt <= '0;
                state <= IDLE;
              end else begin
                i_cnt <= i_cnt + 4'd1;
              end
            end else begin
              c_cnt <= c_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            if (i_last) begin
              i_cnt <= '0;
              j_cnt <= '0;
              state <= OUT;
            end else begin
              i_cnt <= i_cnt + 4'd1;
            end
          end
        end
        OUT: begin
          out_data  <= sat_shift(acc_sel, shift);
          out_valid <= 1'b1;
          out_last  <= j_last;
          if (j_last) begin
            j_cnt <= '0;
            state <= IDLE;
          end else begin
            j_cnt <= j_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_mvm_core.sv
// Directed bench for ternary_mvm_core with a reference matrix model and an output scoreboard.
module tb_ternary_mvm_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  ternary_mvm_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .busy     (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mw[16][16];
  int          m_nin;
  int          m_nout;
  logic [15:0] ws[$];
  logic [7:0]  acts[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL out_spurious: observed out_valid=1 data=%0h expected no output", out_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
      end
    end
  end

  task automatic model_reset();
    m_nin  = 16;
    m_nout = 16;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mw[i][j] = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
  endtask

  task automatic send(input logic [15:0] word, input int stall, input logic exp_busy,
                      input logic hold);
    in_data  = word;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    chk("busy_after_word", 32'(busy), 32'(exp_busy));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      if (hold) chk("busy_in_stall", 32'(busy), 32'd1);
    end
  endtask

  task automatic do_load(input logic [15:0] cmd, input logic [15:0] words[$], input int stall);
    int nch;
    int code;
    logic [15:0] wd;
    m_nin  = (int'(cmd[7:4]) + 1 > 16) ? 16 : int'(cmd[7:4]) + 1;
    m_nout = (int'(cmd[3:0]) + 1 > 16) ? 16 : int'(cmd[3:0]) + 1;
    nch    = (m_nout + 7) / 8;
    send(cmd, stall, 1'b1, 1'b1);
    for (int idx = 0; idx < words.size(); idx++) begin
      wd = words[idx];
      for (int k = 0; k < 8; k++) begin
        code = int'(wd[2*k +: 2]);
        mw[idx / nch][8 * (idx % nch) + k] = (code == 1) ? 1 : (code == 3) ? -1 : 0;
      end
      send(wd, stall, idx != words.size() - 1, idx != words.size() - 1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0 && !busy && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("sb_pending", 32'(sb.size()), 32'd0);
    chk("busy_after_run", 32'(busy), 32'd0);
  endtask

  task automatic do_run(input logic [3:0] sh, input logic [7:0] a[$], input int stall);
    int   acc;
    int   s;
    exp_t e;
    for (int j = 0; j < m_nout; j++) begin
      acc = 0;
      for (int i = 0; i < m_nin; i++) acc += mw[i][j] * int'($signed(a[i]));
      s = acc >>> sh;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      e.d = s[7:0];
      e.l = (j == m_nout - 1);
      sb.push_back(e);
    end
    send({12'h500, sh}, stall, 1'b1, 1'b1);
    for (int idx = 0; idx < a.size(); idx++)
      send({8'($urandom), a[idx]}, stall, 1'b1, idx != a.size() - 1);
    drain();
  endtask

  initial begin
    do_reset();

    // 2x2 load and run, back to back
    ws.delete(); ws.push_back(16'h000D); ws.push_back(16'h0005);
    do_load(16'hA011, ws, 0);
    acts.delete(); acts.push_back(8'h0A); acts.push_back(8'h14);
    chk("t1_model_out0", 32'(mw[0][0] * 10 + mw[1][0] * 20), 32'd30);
    do_run(4'd0, acts, 0);

    // Saturation and shift: 16x8 all +1
    ws.delete();
    for (int i = 0; i < 16; i++) ws.push_back(16'h5555);
    do_load(16'hA0F7, ws, 0);
    acts.delete();
    for (int i = 0; i < 16; i++) acts.push_back(8'h7F);
    do_run(4'd0, acts, 0);
    do_run(4'd5, acts, 0);
    acts.delete();
    for (int i = 0; i < 16; i++) acts.push_back(8'h80);
    do_run(4'd0, acts, 0);

    // Same as the first case with three idle cycles between every word
    ws.delete(); ws.push_back(16'h000D); ws.push_back(16'h0005);
    do_load(16'hA011, ws, 3);
    acts.delete(); acts.push_back(8'h0A); acts.push_back(8'h14);
    do_run(4'd0, acts, 3);

    // Unknown opcode ignored, then run on the zero matrix
    do_reset();
    send(16'h3FFF, 0, 1'b0, 1'b0);
    acts.delete();
    for (int i = 0; i < 16; i++) acts.push_back(8'h55);
    do_run(4'd0, acts, 0);

    // Reset in the middle of a load discards it
    do_reset();
    send(16'hA011, 0, 1'b1, 1'b1);
    send(16'h000D, 0, 1'b1, 1'b1);
    do_reset();
    acts.delete(); acts.push_back(8'h0A); acts.push_back(8'h14);
    for (int i = 0; i < 14; i++) acts.push_back(8'h01);
    do_run(4'd0, acts, 0);

    // Size clamp to 16x16: two chunks per input row, 32 words total
    do_reset();
    ws.delete();
    for (int i = 0; i < 32; i++) ws.push_back(16'($urandom));
    do_load(16'hA0FF, ws, 0);
    acts.delete();
    for (int i = 0; i < 16; i++) acts.push_back(8'($urandom));
    do_run(4'd3, acts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
